// File: rtl/bit_serial_addsub.sv
// Bit-serial adder/subtractor: one full adder plus a carry flip-flop, LSB first.
// Operands load on an accepted start, WL shift steps follow, then a one-cycle done.
// Optional build macro SATURATE_EN clamps the result on signed overflow.
module bit_serial_addsub #(
   parameter int unsigned WL = 8,
   localparam int unsigned CW = $clog2(WL)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          sub,
   input  logic [WL-1:0] a,
   input  logic [WL-1:0] b,
   output logic          busy,
   output logic          done,
   output logic [WL-1:0] sum,
   output logic          sbit,
   output logic          c_out,
   output logic          ovf
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [WL-1:0] a_sr_q, b_sr_q, r_sr_q;
   logic          carry_q;
   logic [CW-1:0] cnt_q;
   logic [WL-1:0] sum_q;
   logic          c_out_q, ovf_q;

   logic          fa_s, fa_co;
   logic          last_step;
   logic          accept;
   logic [WL-1:0] r_next;
   logic [WL-1:0] final_sum;

   // Full adder on the current LSBs, plus step decode and result selection.
   always_comb begin
      fa_s      = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
      fa_co     = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
      last_step = (cnt_q == CW'(WL - 1));
      accept    = start && (state_q != SHIFT);
      r_next    = {fa_s, r_sr_q[WL-1:1]};
`ifdef SATURATE_EN
      // On the final step a_sr_q[0] holds the MSB of operand a.
      if (fa_co ^ carry_q) begin
         final_sum = a_sr_q[0] ? {1'b1, {(WL-1){1'b0}}} : {1'b0, {(WL-1){1'b1}}};
      end else begin
         final_sum = r_next;
      end
`else
      final_sum = r_next;
`endif
   end

   // Next-state logic for the IDLE/SHIFT/DONE controller.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (last_step) state_d = DONE;
         DONE:    state_d = start ? SHIFT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand shift registers, carry, counter and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         r_sr_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (state_q == SHIFT) begin
         a_sr_q  <= {1'b0, a_sr_q[WL-1:1]};
         b_sr_q  <= {1'b0, b_sr_q[WL-1:1]};
         r_sr_q  <= r_next;
         carry_q <= fa_co;
         cnt_q   <= cnt_q + CW'(1);
         if (last_step) begin
            sum_q   <= final_sum;
            c_out_q <= fa_co;
            // Carry into the MSB differs from carry out of it.
            ovf_q   <= fa_co ^ carry_q;
         end
      end else if (accept) begin
         a_sr_q  <= a;
         // Subtraction as a + ~b + 1: invert b and seed the carry.
         b_sr_q  <= sub ? ~b : b;
         carry_q <= sub;
         cnt_q   <= '0;
      end
   end

   assign busy  = (state_q == SHIFT);
   assign done  = (state_q == DONE);
   assign sbit  = (state_q == SHIFT) ? fa_s : 1'b0;
   assign sum   = sum_q;
   assign c_out = c_out_q;
   assign ovf   = ovf_q;

endmodule
